// File: rtl/mgs_seq_pkg.sv
// Shared definitions for the magic-streamer control sequencer.
// Holds the state encoding, error codes and the core pulse selector.
package mgs_seq_pkg;

  localparam int unsigned STATE_W    = 4;
  localparam int unsigned ERR_CODE_W = 2;

  // State encoding; also visible on dbg_state
  localparam logic [STATE_W-1:0] ST_IDLE    = 4'd0;
  localparam logic [STATE_W-1:0] ST_S_RST   = 4'd1;
  localparam logic [STATE_W-1:0] ST_S_INIT  = 4'd2;
  localparam logic [STATE_W-1:0] ST_S_WAIT  = 4'd3;
  localparam logic [STATE_W-1:0] ST_L_RST   = 4'd4;
  localparam logic [STATE_W-1:0] ST_L_INIT  = 4'd5;
  localparam logic [STATE_W-1:0] ST_L_WAIT  = 4'd6;
  localparam logic [STATE_W-1:0] ST_L_DRAIN = 4'd7;
  localparam logic [STATE_W-1:0] ST_ERR     = 4'd8;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = ST_IDLE,
    S_RST   = ST_S_RST,
    S_INIT  = ST_S_INIT,
    S_WAIT  = ST_S_WAIT,
    L_RST   = ST_L_RST,
    L_INIT  = ST_L_INIT,
    L_WAIT  = ST_L_WAIT,
    L_DRAIN = ST_L_DRAIN,
    ERR     = ST_ERR
  } state_e;

  localparam logic [ERR_CODE_W-1:0] ERR_NONE    = 2'b00;
  localparam logic [ERR_CODE_W-1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [ERR_CODE_W-1:0] ERR_ABORT   = 2'b10;
  localparam logic [ERR_CODE_W-1:0] ERR_NODATA  = 2'b11;

  // At most one single-cycle pulse is issued per cycle
  typedef enum logic [2:0] {
    PULSE_NONE,
    PULSE_STORE_RST,
    PULSE_STORE_INIT,
    PULSE_LOAD_RST,
    PULSE_LOAD_INIT,
    PULSE_DONE
  } pulse_e;

endpackage

// File: rtl/mgs_stream_seq_if.sv
// Host/core-facing signal bundle of the sequencer.
// master: host side (commands, core snoops in; status, core controls out of DUT)
// slave : sequencer side.
interface mgs_stream_seq_if #(
  parameter int unsigned STORAGE_IDX_WIDTH = 10,
  parameter int unsigned STATE_BIT_WIDTH   = 4
);
  logic                         cmd_save;
  logic                         cmd_restore;
  logic                         cmd_abort;
  logic                         cmd_clear;
  logic                         core_fin_store;
  logic                         mon_s_tvalid;
  logic                         mon_m_tvalid;
  logic                         mon_m_tready;
  logic                         mon_m_tlast;
  logic                         storeReset;
  logic                         loadReset;
  logic                         storeInit;
  logic                         loadInit;
  logic                         busy;
  logic                         done;
  logic                         err;
  logic [1:0]                   err_code;
  logic                         have_data;
  logic [STORAGE_IDX_WIDTH-1:0] save_beats;
  logic [STORAGE_IDX_WIDTH-1:0] restore_beats;
  logic [STATE_BIT_WIDTH-1:0]   dbg_state;

  modport master (
    output cmd_save, cmd_restore, cmd_abort, cmd_clear, core_fin_store,
           mon_s_tvalid, mon_m_tvalid, mon_m_tready, mon_m_tlast,
    input  storeReset, loadReset, storeInit, loadInit, busy, done, err,
           err_code, have_data, save_beats, restore_beats, dbg_state
  );

  modport slave (
    input  cmd_save, cmd_restore, cmd_abort, cmd_clear, core_fin_store,
           mon_s_tvalid, mon_m_tvalid, mon_m_tready, mon_m_tlast,
    output storeReset, loadReset, storeInit, loadInit, busy, done, err,
           err_code, have_data, save_beats, restore_beats, dbg_state
  );
endinterface

// File: rtl/mgs_watchdog.sv
// Stall watchdog: counts enabled cycles, cleared by clr_i.
// expire_o (registered) is high in the cycle the count sits at TIMEOUT_CYCLES-1.
// Ports: clk, reset (sync, active high), clr_i, en_i, expire_o.
module mgs_watchdog #(
  parameter int unsigned TIMEOUT_WIDTH  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     expire_q, expire_d;

  // Expiry is decided one count early so the flag lines up with the final count
  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d    = cnt_q + TIMEOUT_WIDTH'(1);
      expire_d = (cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 2));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;
endmodule

// File: rtl/mgs_stream_seq.sv
// Control-side sequencer for the magic streamer core: expands save/restore
// commands into reset/init pulses, tracks completion, counts beats, and
// reports timeout/abort/no-data errors. All outputs are registered.
// Ports: clk, reset (sync, active high), bus (mgs_stream_seq_if.slave).
module mgs_stream_seq
  import mgs_seq_pkg::*;
#(
  parameter int unsigned STORAGE_IDX_WIDTH = 10,
  parameter int unsigned TIMEOUT_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES    = 50000,
  parameter int unsigned STATE_BIT_WIDTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  mgs_stream_seq_if.slave bus
);
  localparam int unsigned SW = STORAGE_IDX_WIDTH;
  localparam logic [SW-1:0] BEATS_MAX = '1;

  state_e                state_q, state_d;
  logic [SW-1:0]         save_beats_q, save_beats_d;
  logic [SW-1:0]         restore_beats_q, restore_beats_d;
  logic                  have_data_q, have_data_d;
  logic [ERR_CODE_W-1:0] err_code_q, err_code_d;
  logic                  drain_q, drain_d;
  logic                  busy_q, err_q, done_q;
  logic                  store_reset_q, store_init_q, load_reset_q, load_init_q;
  pulse_e                pulse_d;
  logic                  wd_clr, wd_en, wd_expire;
  logic                  s_beat, m_beat;

  assign s_beat = bus.mon_s_tvalid;
  assign m_beat = bus.mon_m_tvalid & bus.mon_m_tready;

  mgs_watchdog #(
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (wd_clr),
    .en_i    (wd_en),
    .expire_o(wd_expire)
  );

  // Next state, counters and pulse selection; abort is checked first everywhere
  always_comb begin
    state_d         = state_q;
    save_beats_d    = save_beats_q;
    restore_beats_d = restore_beats_q;
    have_data_d     = have_data_q;
    err_code_d      = err_code_q;
    drain_d         = 1'b0;
    pulse_d         = PULSE_NONE;
    wd_clr          = 1'b0;
    wd_en           = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_save) begin
          state_d      = S_RST;
          save_beats_d = '0;
          have_data_d  = 1'b0;
        end else if (bus.cmd_restore) begin
          if (have_data_q) begin
            state_d         = L_RST;
            restore_beats_d = '0;
          end else begin
            state_d    = ERR;
            err_code_d = ERR_NODATA;
          end
        end
      end
      S_RST, S_INIT, L_RST, L_INIT: begin
        if (bus.cmd_abort) begin
          state_d    = ERR;
          err_code_d = ERR_ABORT;
        end else begin
          case (state_q)
            S_RST:   begin state_d = S_INIT; pulse_d = PULSE_STORE_RST;  end
            S_INIT:  begin state_d = S_WAIT; pulse_d = PULSE_STORE_INIT; wd_clr = 1'b1; end
            L_RST:   begin state_d = L_INIT; pulse_d = PULSE_LOAD_RST;   end
            default: begin state_d = L_WAIT; pulse_d = PULSE_LOAD_INIT;  wd_clr = 1'b1; end
          endcase
        end
      end
      S_WAIT: begin
        wd_en  = 1'b1;
        wd_clr = s_beat;
        if (s_beat && save_beats_q != BEATS_MAX) save_beats_d = save_beats_q + SW'(1);
        if (bus.cmd_abort) begin
          state_d    = ERR;
          err_code_d = ERR_ABORT;
        end else if (bus.core_fin_store) begin
          state_d     = IDLE;
          have_data_d = 1'b1;
          pulse_d     = PULSE_DONE;
        end else if (wd_expire && !s_beat) begin
          state_d    = ERR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      L_WAIT: begin
        wd_en  = 1'b1;
        wd_clr = m_beat;
        if (m_beat && restore_beats_q != BEATS_MAX) restore_beats_d = restore_beats_q + SW'(1);
        if (bus.cmd_abort) begin
          state_d    = ERR;
          err_code_d = ERR_ABORT;
        end else if (m_beat && bus.mon_m_tlast) begin
          state_d = L_DRAIN;
        end else if (wd_expire && !m_beat) begin
          state_d    = ERR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      L_DRAIN: begin
        // Two cycles let the core settle back to idle before reporting done
        if (bus.cmd_abort) begin
          state_d    = ERR;
          err_code_d = ERR_ABORT;
        end else if (drain_q) begin
          state_d = IDLE;
          pulse_d = PULSE_DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      ERR: begin
        if (bus.cmd_clear) begin
          state_d     = IDLE;
          err_code_d  = ERR_NONE;
          have_data_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      save_beats_q    <= '0;
      restore_beats_q <= '0;
      have_data_q     <= 1'b0;
      err_code_q      <= ERR_NONE;
      drain_q         <= 1'b0;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
      done_q          <= 1'b0;
      store_reset_q   <= 1'b0;
      store_init_q    <= 1'b0;
      load_reset_q    <= 1'b0;
      load_init_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      save_beats_q    <= save_beats_d;
      restore_beats_q <= restore_beats_d;
      have_data_q     <= have_data_d;
      err_code_q      <= err_code_d;
      drain_q         <= drain_d;
      busy_q          <= (state_d != IDLE);
      err_q           <= (state_d == ERR);
      done_q          <= (pulse_d == PULSE_DONE);
      store_reset_q   <= (pulse_d == PULSE_STORE_RST);
      store_init_q    <= (pulse_d == PULSE_STORE_INIT);
      load_reset_q    <= (pulse_d == PULSE_LOAD_RST);
      load_init_q     <= (pulse_d == PULSE_LOAD_INIT);
    end
  end

  assign bus.storeReset    = store_reset_q;
  assign bus.storeInit     = store_init_q;
  assign bus.loadReset     = load_reset_q;
  assign bus.loadInit      = load_init_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.err_code      = err_code_q;
  assign bus.have_data     = have_data_q;
  assign bus.save_beats    = save_beats_q;
  assign bus.restore_beats = restore_beats_q;
  assign bus.dbg_state     = STATE_BIT_WIDTH'(state_q);
endmodule
